mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter that shares one RAM port between the instruction fetch path and the load/store path of the rvcpu core. It accepts requests from both, grants one at a time with data-side priority and a starvation guard for fetch, drives the RAM handshake, and returns read data with a one-cycle acknowledge pulse. It sits between if_stage/mem_stage and the memory model, replacing their separate memory ports.

## Interface
- STARVE_LIMIT, 4: maximum consecutive mem grants while if_req is pending; must be ≥1.

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  64  fetch byte address; bits [1:0] ignored.
- if_ack  out  1  one-cycle pulse; if_rdata valid in this cycle.
- if_rdata  out  32  fetched instruction.
- mem_req  in  1  load/store request; held until mem_ack.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  64  data byte address.
- mem_wdata  in  64  store data.
- mem_wmask  in  8  store byte enables.
- mem_ack  out  1  one-cycle pulse; mem_rdata valid in this cycle.
- mem_rdata  out  64  load data.
- ram_valid  out  1  RAM request valid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  64  RAM byte address.
- ram_wdata  out  64  RAM write data.
- ram_wmask  out  8  RAM byte enables.
- ram_ready  in  1  RAM accepts/completes the request this cycle.
- ram_rdata  in  64  RAM read data; valid when ram_valid && ram_ready.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any request is present, select a winner, register its fields into the ram_* registers and a grant-id register, then go to BUSY. If no request is present, stay in IDLE.
- Selection rule:
  - Only one request present: that requester wins.
  - Both present: mem wins, unless streak == STARVE_LIMIT, in which case if wins.
- Streak counter (width $clog2(STARVE_LIMIT+1)):
  - On a mem grant while if_req = 1: increment, saturating at STARVE_LIMIT.
  - On an if grant: clear to 0.
  - On a mem grant while if_req = 0: clear to 0.
- IF grant drives ram_we = 0, ram_wmask = 0, ram_wdata = 0, and ram_addr = {if_addr[63:3], 3'b0}. The latched if_addr[2] selects the returned word: 0 → ram_rdata[31:0], 1 → ram_rdata[63:32].
- MEM grant drives mem_addr, mem_we, mem_wdata, and mem_wmask unmodified. Loads return all 64 bits of ram_rdata.
- BUSY: hold ram_valid = 1 and all ram_* fields stable until ram_ready. On the ram_valid && ram_ready cycle:
  - capture read data into the granted requester's rdata register (stores capture nothing);
  - go to RESP.
- RESP: pulse if_ack or mem_ack according to grant-id, deassert ram_valid, go to IDLE.
- rdata outputs hold their last captured value until the next completion for the same requester.
- A requester dropping req while granted is ignored: the transaction completes and ack still pulses.
- Requesters must present the next request (or drop req) in the cycle after ack. The arbiter does not sample requests in RESP.
- Reset mid-transaction: the next cycle is IDLE with ram_valid = 0. The in-flight RAM access is abandoned, no ack is generated, and the streak counter is cleared.

## Timing
- Reset values: if_ack = 0, mem_ack = 0, ram_valid = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, ram_wmask = 0, if_rdata = 0, mem_rdata = 0, state = IDLE, streak = 0.
- Request sampled in IDLE at cycle N → ram_valid = 1 from N+1.
- ram_ready at cycle M ≥ N+1 → ack = 1 at M+1 only → IDLE at M+2.
- Zero-wait RAM (ram_ready = 1 at N+1): ack at N+2. Minimum spacing between grants is 3 cycles.
- All outputs are registered. There is no combinational path from req or ram_ready to any output.

## Test plan
- IF alone: if_addr = 0x8000_0004, ram_ready two cycles after ram_valid rises, ram_rdata = 0x1111_2222_3333_4444. Required: ram_addr = 0x8000_0000, ram_we = 0, exactly one if_ack cycle, if_rdata = 0x1111_2222.
- Simultaneous requests at cycle N (if 0x8000_0000, mem load 0x8000_1000), zero-wait RAM. Required: mem granted first (mem_ack at N+2), then fetch served, with if_ack at N+5.
- Starvation, STARVE_LIMIT = 4: mem_req held high continuously, if_req held high. Required: exactly 4 mem grants, then 1 if grant, then mem again. Streak reads 0 after the if grant.
- Store: mem_we = 1, addr 0x8000_0010, wdata 0xDEAD_BEEF_0000_0001, wmask 0x0F. Required: ram_* fields match exactly and stay stable across 3 wait cycles, mem_ack pulses once, mem_rdata is unchanged.
- Reset mid-BUSY: rst asserted for 1 cycle while ram_valid = 1. Required: ram_valid = 0 next cycle, no ack, and a subsequent if_req is served normally.
- Requester drops req during BUSY. Required: the transaction still completes and ack pulses once, with no regrant.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and
// load/store. Data side wins ties unless fetch has been passed over
// STARVE_LIMIT times in a row. One transaction in flight at a time;
// every requester sees a one-cycle registered ack with its read data.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  output logic        mem_ack,
  output logic [63:0] mem_rdata,
  output logic        ram_valid,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [7:0]  ram_wmask,
  input  logic        ram_ready,
  input  logic [63:0] ram_rdata
);

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned INSN_W   = 32;
  localparam int unsigned MASK_W   = 8;
  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_mem_q, gnt_mem_d;
  logic                word_hi_q, word_hi_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic                ram_valid_d;
  logic                ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_d;
  logic [MASK_W-1:0]   ram_wmask_d;
  logic                if_ack_d;
  logic                mem_ack_d;
  logic [INSN_W-1:0]   if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_d;
  logic                pick_mem;

  // Fetch addresses are word aligned; the low two bits carry no meaning.
  logic if_addr_unused;
  assign if_addr_unused = &{1'b0, if_addr[1:0]};

  // State, grant bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_mem_q <= 1'b0;
      word_hi_q <= 1'b0;
      streak_q  <= '0;
      ram_valid <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wmask <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      gnt_mem_q <= gnt_mem_d;
      word_hi_q <= word_hi_d;
      streak_q  <= streak_d;
      ram_valid <= ram_valid_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      ram_wmask <= ram_wmask_d;
      if_ack    <= if_ack_d;
      mem_ack   <= mem_ack_d;
      if_rdata  <= if_rdata_d;
      mem_rdata <= mem_rdata_d;
    end
  end

  // Arbitration, RAM handshake sequencing and response capture.
  always_comb begin
    state_d     = state_q;
    gnt_mem_d   = gnt_mem_q;
    word_hi_d   = word_hi_q;
    streak_d    = streak_q;
    ram_valid_d = ram_valid;
    ram_we_d    = ram_we;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    ram_wmask_d = ram_wmask;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata;
    mem_rdata_d = mem_rdata;
    pick_mem    = mem_req && (!if_req || (streak_q != STREAK_MAX));

    case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          state_d     = BUSY;
          ram_valid_d = 1'b1;
          gnt_mem_d   = pick_mem;
          if (pick_mem) begin
            ram_we_d    = mem_we;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
            ram_wmask_d = mem_wmask;
            // Streak only grows while fetch is actually waiting.
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else begin
            ram_we_d    = 1'b0;
            ram_addr_d  = {if_addr[ADDR_W-1:3], 3'b000};
            ram_wdata_d = '0;
            ram_wmask_d = '0;
            word_hi_d   = if_addr[2];
            streak_d    = '0;
          end
        end
      end

      BUSY: begin
        if (ram_valid && ram_ready) begin
          state_d     = RESP;
          ram_valid_d = 1'b0;
          if (gnt_mem_q) begin
            mem_ack_d = 1'b1;
            if (!ram_we) begin
              mem_rdata_d = ram_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = word_hi_q ? ram_rdata[63:32] : ram_rdata[31:0];
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        ram_valid_d = 1'b0;
      end
    endcase
  end

endmodule
